// File: rtl/param_sram_loader_pkg.sv
// Shared EPU definitions for the parameter-SRAM loader: state encoding and
// default geometry of the 5 x 32-bit parameter SRAM.
package param_sram_loader_pkg;

   localparam int PARAM_WORDS  = 5;
   localparam int PARAM_ADDR_W = 3;
   localparam int PARAM_DATA_W = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_CHK   = 2'd2,
      S_FLUSH = 2'd3
   } ldr_state_e;

endpackage

// File: rtl/param_sram_wr_reg.sv
// Registered SRAM write-port stage: presents one write in the cycle after
// we_i, and holds address/data while no write is requested.
module param_sram_wr_reg
   import param_sram_loader_pkg::*;
#(
   parameter int ADDR_W = PARAM_ADDR_W,
   parameter int DATA_W = PARAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              cs_o,
   output logic              w_req_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o
);

   logic              cs_q, cs_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      cs_d   = we_i;
      addr_d = addr_q;
      data_d = data_q;
      if (we_i) begin
         addr_d = addr_i;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         cs_q   <= cs_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   // W_req is active-low and only ever asserted together with cs.
   assign cs_o    = cs_q;
   assign w_req_o = ~cs_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;

endmodule

// File: rtl/param_sram_loader.sv
// Streams WORDS parameter words into the EPU parameter SRAM at addresses
// 0..WORDS-1. Optional checksum word check enabled by PARAM_LOAD_CHECKSUM_EN.
module param_sram_loader
   import param_sram_loader_pkg::*;
#(
   parameter int ADDR_W = PARAM_ADDR_W,
   parameter int DATA_W = PARAM_DATA_W,
   parameter int WORDS  = PARAM_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic              mem_W_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_W_data
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

   ldr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              hs;
   logic              wr_en;

`ifdef PARAM_LOAD_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              err_q, err_d;
`endif

   assign in_ready = (state_q == S_LOAD) || (state_q == S_CHK);
   assign hs       = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
`ifdef PARAM_LOAD_CHECKSUM_EN
      sum_d   = sum_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
`ifdef PARAM_LOAD_CHECKSUM_EN
               sum_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         S_LOAD: begin
            // A word arriving together with abort is dropped, not written.
            if (abort) begin
               state_d = S_IDLE;
            end else if (hs) begin
               wr_en = 1'b1;
`ifdef PARAM_LOAD_CHECKSUM_EN
               sum_d = sum_q + in_data;
`endif
               if (cnt_q == LAST_IDX) begin
`ifdef PARAM_LOAD_CHECKSUM_EN
                  state_d = S_CHK;
`else
                  state_d = S_FLUSH;
`endif
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
`ifdef PARAM_LOAD_CHECKSUM_EN
         S_CHK: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (hs) begin
               if (in_data != sum_q) err_d = 1'b1;
               state_d = S_FLUSH;
            end
         end
`endif
         S_FLUSH: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
`ifdef PARAM_LOAD_CHECKSUM_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef PARAM_LOAD_CHECKSUM_EN
         err_q   <= err_d;
`endif
      end
   end

`ifdef PARAM_LOAD_CHECKSUM_EN
   // Accumulator is cleared on every start, so it needs no reset.
   always_ff @(posedge clk) begin
      sum_q <= sum_d;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   param_sram_wr_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wr_reg (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en),
      .addr_i  (cnt_q),
      .data_i  (in_data),
      .cs_o    (mem_cs),
      .w_req_o (mem_W_req),
      .addr_o  (mem_addr),
      .data_o  (mem_W_data)
   );

   assign mem_oe = 1'b0;
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_FLUSH);

endmodule

// File: tb/tb_param_sram_loader.sv
// Directed/randomized bench for param_sram_loader with a behavioural SRAM and
// a transaction-level expectation model; checksum cases under PARAM_LOAD_CHECKSUM_EN.
module tb_param_sram_loader;

   localparam int WORDS  = 5;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst, start, abort, in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, busy, done, err;
   logic              mem_cs, mem_oe, mem_W_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_W_data;

   always #5 clk = ~clk;

   param_sram_loader #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .WORDS  (WORDS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .mem_cs     (mem_cs),
      .mem_oe     (mem_oe),
      .mem_W_req  (mem_W_req),
      .mem_addr   (mem_addr),
      .mem_W_data (mem_W_data)
   );

   // Behavioural single-port SRAM driven by the loader
   logic [DATA_W-1:0] sram [8];
   always @(posedge clk) begin
      if (mem_cs && !mem_W_req) sram[mem_addr] <= mem_W_data;
   end

   // Expectation model
   logic [DATA_W-1:0] exp_mem [8];
   logic [DATA_W-1:0] words [WORDS];
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic              m_err;
   int                n_pass = 0;
   int                n_fail = 0;
   int                n_total = 0;
`ifdef PARAM_LOAD_CHECKSUM_EN
   logic [DATA_W-1:0] cks_word;

   function automatic logic [DATA_W-1:0] word_sum();
      logic [DATA_W-1:0] s = '0;
      for (int k = 0; k < WORDS; k++) s = s + words[k];
      return s;
   endfunction
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic e_ready, input logic e_busy,
                            input logic e_done, input logic e_cs);
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(e_ready));
      chk({tag, ".busy"}, 64'(busy), 64'(e_busy));
      chk({tag, ".done"}, 64'(done), 64'(e_done));
      chk({tag, ".mem_cs"}, 64'(mem_cs), 64'(e_cs));
      chk({tag, ".mem_W_req"}, 64'(mem_W_req), 64'(!e_cs));
      chk({tag, ".mem_oe"}, 64'(mem_oe), 64'd0);
      chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(m_addr));
      chk({tag, ".mem_W_data"}, 64'(mem_W_data), 64'(m_data));
      chk({tag, ".err"}, 64'(err), 64'(m_err));
   endtask

   task automatic idle_out(input string tag);
      check_out(tag, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic readback(input string tag);
      for (int k = 0; k < WORDS; k++) chk(tag, 64'(sram[k]), 64'(exp_mem[k]));
   endtask

   task automatic rand_words();
      for (int k = 0; k < WORDS; k++) words[k] = $urandom;
   endtask

   // One load: optional bubbles, optional kill (abort or rst) coinciding
   // with the handshake of word kill_idx, optional start held throughout.
   task automatic run_load(input int gap_max, input int kill_idx, input bit kill_rst,
                           input bit start_noise);
      bit pend = 1'b0;
      int gaps;
      idle_out("pre_start");
      start = 1'b1;
      @(negedge clk);
      m_err = 1'b0;
      start = start_noise;
      for (int i = 0; i < WORDS; i++) begin
         gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
         repeat (gaps) begin
            check_out("load_gap", 1'b1, 1'b1, 1'b0, pend);
            pend = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
         end
         check_out("load_word", 1'b1, 1'b1, 1'b0, pend);
         in_valid = 1'b1;
         in_data  = words[i];
         if (i == kill_idx) begin
            if (kill_rst) begin
               rst   = 1'b1;
               start = 1'b1;
            end else begin
               abort = 1'b1;
            end
         end
         @(negedge clk);
         if (i == kill_idx) begin
            in_valid = 1'b0;
            rst      = 1'b0;
            abort    = 1'b0;
            start    = 1'b0;
            if (kill_rst) begin
               m_addr = '0;
               m_data = '0;
               m_err  = 1'b0;
            end
            idle_out(kill_rst ? "after_rst" : "after_abort");
            @(negedge clk);
            idle_out("killed_idle");
            readback("readback_killed");
            return;
         end
         pend       = 1'b1;
         m_addr     = ADDR_W'(i);
         m_data     = words[i];
         exp_mem[i] = words[i];
      end
      in_valid = 1'b0;
`ifdef PARAM_LOAD_CHECKSUM_EN
      check_out("chk_word", 1'b1, 1'b1, 1'b0, pend);
      pend     = 1'b0;
      in_valid = 1'b1;
      in_data  = cks_word;
      @(negedge clk);
      in_valid = 1'b0;
      m_err    = (cks_word != word_sum());
`endif
      check_out("flush", 1'b0, 1'b1, 1'b1, pend);
      @(negedge clk);
      start = 1'b0;
      idle_out("post_done");
      @(negedge clk);
      idle_out("post_idle");
      readback("readback");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      m_addr = '0; m_data = '0; m_err = 1'b0;
      repeat (2) @(negedge clk);
      idle_out("reset");
      rst = 1'b0;
      @(negedge clk);
      idle_out("reset_release");

      // Basic back-to-back load
      for (int k = 0; k < WORDS; k++) words[k] = DATA_W'(32'h11 * (k + 1));
`ifdef PARAM_LOAD_CHECKSUM_EN
      cks_word = word_sum();
`endif
      run_load(0, -1, 1'b0, 1'b0);

      // Bubbles with random data; second pass also holds start while busy
      for (int r = 0; r < 3; r++) begin
         rand_words();
`ifdef PARAM_LOAD_CHECKSUM_EN
         cks_word = word_sum();
`endif
         run_load(3, -1, 1'b0, r == 1);
      end

      // Abort together with the third handshake, then a clean reload
      rand_words();
      run_load(2, 2, 1'b0, 1'b0);
      rand_words();
`ifdef PARAM_LOAD_CHECKSUM_EN
      cks_word = word_sum();
`endif
      run_load(0, -1, 1'b0, 1'b0);

      // Stream traffic while idle must be ignored
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         @(negedge clk);
         idle_out("idle_valid");
      end
      in_valid = 1'b0;
      @(negedge clk);
      readback("readback_idle_valid");

      // Reset in the middle of a load, then a clean reload
      rand_words();
      run_load(1, 2, 1'b1, 1'b0);
      rand_words();
`ifdef PARAM_LOAD_CHECKSUM_EN
      cks_word = word_sum();
`endif
      run_load(1, -1, 1'b0, 1'b0);

`ifdef PARAM_LOAD_CHECKSUM_EN
      for (int k = 0; k < WORDS; k++) words[k] = DATA_W'(k + 1);
      cks_word = 32'd15;
      run_load(0, -1, 1'b0, 1'b0);
      cks_word = 32'd16;
      run_load(1, -1, 1'b0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         idle_out("err_held");
      end
      for (int k = 0; k < WORDS; k++) words[k] = 32'hFFFF_FFFF;
      cks_word = 32'hFFFF_FFFB;
      run_load(0, -1, 1'b0, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
